keypad_scanner: RTL and testbench

- Upstream stage of the calculator FSM; scans the 4x4 matrix keypad on GPIO_0.
- Drives the rows, reads the columns and debounces both press and release.
- Outputs a 4-bit key code with a single-cycle key_press strobe, which the FSM consumes as value/key_press.
- Runs on CLOCK_50, using an internal scan-tick enable; there is no derived clock.

---
 rtl/keypad_scanner_pkg.sv | 62 ++++++
 rtl/keypad_scanner_tick_gen.sv | 25 ++
 rtl/keypad_scanner.sv | 139 +++++++++++++
 tb/tb_keypad_scanner.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Key codes follow the printed legend; letters and symbols map to 10..15.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // A lone low column is a key; zero or several low columns mean "no key".
    function automatic logic one_low(input logic [3:0] cols);
        int n;
        n = 0;
        for (int i = 0; i < NUM_COLS; i++)
            if (!cols[i]) n++;
        return (n == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_ROWS; i++)
            if (!bits[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running divider that produces a one-cycle enable every CLK_DIV clocks.
// Also used to pace the display multiplexer.
module tick_gen #(
    parameter int CLK_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks one low row, debounces press and release on scan ticks,
// and reports each accepted key as a code with a one-cycle key_press strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] value,
    output logic       key_press,
    output logic       key_held,
    output state_t     o_dbg_state
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [3:0]    r_col_s1;
    logic [3:0]    r_col_s2;
    logic [3:0]    r_cap;
    logic [3:0]    r_row;
    logic [3:0]    r_value;
    logic          r_key_press;
    logic          r_key_held;
    logic [CW-1:0] r_cnt;
    state_t        r_state;

    logic          w_tick;
    logic          w_valid;
    logic          w_all_high;
    logic          w_cnt_done;
    logic [3:0]    w_code;
    logic [3:0]    w_row_next;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .o_tick  (w_tick)
    );

    assign w_valid    = one_low(r_col_s2);
    assign w_all_high = (r_col_s2 == 4'hF);
    assign w_cnt_done = (int'(r_cnt) + 1 >= DEBOUNCE_TICKS);
    assign w_code     = key_code(low_index(r_row), low_index(r_col_s2));
    assign w_row_next = {r_row[2:0], r_row[3]};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_col_s1    <= '0;
            r_col_s2    <= '0;
            r_cap       <= 4'hF;
            r_row       <= 4'b1110;
            r_value     <= '0;
            r_key_press <= 1'b0;
            r_key_held  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= SCAN;
        end else begin
            r_col_s1    <= col_in;
            r_col_s2    <= r_col_s1;
            r_key_press <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_valid) begin
                            r_cap <= r_col_s2;
                            r_cnt <= CW'(1);
                            // The detection tick already counts as the first stable sample.
                            if (DEBOUNCE_TICKS <= 1) begin
                                r_state     <= PRESSED;
                                r_value     <= w_code;
                                r_key_press <= 1'b1;
                                r_key_held  <= 1'b1;
                            end else begin
                                r_state <= DEBOUNCE;
                            end
                        end else begin
                            r_row <= w_row_next;
                        end
                    end
                    DEBOUNCE: begin
                        if (r_col_s2 == r_cap) begin
                            if (w_cnt_done) begin
                                r_cnt       <= CW'(DEBOUNCE_TICKS);
                                r_state     <= PRESSED;
                                r_value     <= w_code;
                                r_key_press <= 1'b1;
                                r_key_held  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_row   <= w_row_next;
                            r_state <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (w_all_high) begin
                            if (DEBOUNCE_TICKS <= 1) begin
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                                r_row      <= w_row_next;
                                r_state    <= SCAN;
                            end else begin
                                r_cnt   <= CW'(1);
                                r_state <= RELEASE;
                            end
                        end
                    end
                    default: begin
                        // Any low column here is release bounce: back to held, no new strobe.
                        if (w_all_high) begin
                            if (w_cnt_done) begin
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                                r_row      <= w_row_next;
                                r_state    <= SCAN;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_state <= PRESSED;
                        end
                    end
                endcase
            end
        end
    end

    assign row_out     = r_row;
    assign value       = r_value;
    assign key_press   = r_key_press;
    assign key_held    = r_key_held;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner with a physical keypad model
// and a tick-level reference of the scan/debounce rules.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DT      = 3;

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_PRS  = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] value;
    logic       key_press;
    logic       key_held;
    state_t     dbg_state;

    // keys[r][c] = 1 means the switch at row r / column c is closed.
    logic [3:0] keys [4];

    int         n_cmp = 0;
    int         n_err = 0;

    int         m_row;
    int         m_mode;
    int         m_cnt;
    logic [3:0] m_cap;
    logic [3:0] m_val;
    logic       m_held;
    logic       m_press;
    int         m_presses = 0;
    int         obs_presses = 0;
    logic [3:0] exp_q[$];

    logic [3:0] code_tab [16] = '{4'd1, 4'd2, 4'd3, 4'd10,
                                  4'd4, 4'd5, 4'd6, 4'd11,
                                  4'd7, 4'd8, 4'd9, 4'd12,
                                  4'd14, 4'd0, 4'd15, 4'd13};

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DT)) dut (
        .CLOCK_50    (clk),
        .reset_n     (rst_n),
        .col_in      (col_in),
        .row_out     (row_out),
        .value       (value),
        .key_press   (key_press),
        .key_held    (key_held),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Passive matrix: a closed switch pulls its column low when its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_out[r]) col_in = col_in & ~keys[r];
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int low_col(input logic [3:0] c);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++)
            if (!c[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        m_row  = 0;
        m_mode = M_SCAN;
        m_cnt  = 0;
        m_cap  = 4'hF;
        m_val  = 4'd0;
        m_held = 1'b0;
        m_press = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept();
        m_mode  = M_PRS;
        m_val   = code_tab[4'(m_row * 4 + low_col(m_cap))];
        m_press = 1'b1;
        m_held  = 1'b1;
        m_presses++;
        exp_q.push_back(m_val);
    endtask

    // One scan tick of the reference: what the keypad shows on the driven row decides the move.
    task automatic model_step();
        logic [3:0] cols;
        int nlow;
        cols = ~keys[m_row];
        nlow = 0;
        for (int c = 0; c < 4; c++)
            if (!cols[c]) nlow++;
        m_press = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (nlow == 1) begin
                    m_cap = cols;
                    m_cnt = 1;
                    if (m_cnt >= DT) model_accept();
                    else m_mode = M_DEB;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
            M_DEB: begin
                if (cols == m_cap) begin
                    m_cnt++;
                    if (m_cnt >= DT) model_accept();
                end else begin
                    m_cnt  = 0;
                    m_row  = (m_row + 1) % 4;
                    m_mode = M_SCAN;
                end
            end
            M_PRS: begin
                if (cols == 4'hF) begin
                    m_cnt  = 1;
                    m_mode = M_REL;
                end
            end
            default: begin
                if (cols == 4'hF) begin
                    m_cnt++;
                    if (m_cnt >= DT) begin
                        m_held = 1'b0;
                        m_cnt  = 0;
                        m_row  = (m_row + 1) % 4;
                        m_mode = M_SCAN;
                    end
                end else begin
                    m_mode = M_PRS;
                end
            end
        endcase
    endtask

    task automatic tick();
        logic [3:0] exp_row;
        logic [3:0] popped;
        for (int i = 0; i < CLK_DIV; i++) begin
            @(posedge clk);
            #1;
            if (i < CLK_DIV - 1) check("press_between_ticks", 8'(key_press), 8'd0);
        end
        model_step();
        exp_row = 4'hF ^ (4'd1 << m_row);
        check("row_out", 8'(row_out), 8'(exp_row));
        check("key_press", 8'(key_press), 8'(m_press));
        check("value", 8'(value), 8'(m_val));
        check("key_held", 8'(key_held), 8'(m_held));
        if (key_press === 1'b1) begin
            obs_presses++;
            check("press_expected", 8'(exp_q.size() != 0), 8'd1);
            if (exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                check("scoreboard_code", 8'(value), 8'(popped));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_row_out", 8'(row_out), 8'hE);
        check("rst_value", 8'(value), 8'd0);
        check("rst_key_press", 8'(key_press), 8'd0);
        check("rst_key_held", 8'(key_held), 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int reached;
        int r;
        logic [3:0] pat;

        for (int i = 0; i < 4; i++) keys[i] = 4'h0;
        model_reset();

        // Reset, idle scanning
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(9);

        // Key 6 held clean, then released
        keys[1] = 4'b0100;
        ticks(10);
        keys[1] = 4'b0000;
        ticks(6);

        // '*' with press bounce
        keys[3] = 4'b0001; tick();
        keys[3] = 4'b0000; tick();
        keys[3] = 4'b0001; tick();
        ticks(8);
        keys[3] = 4'b0000;
        ticks(6);

        // Key 5 with release bounce, plus a second key while held
        keys[1] = 4'b0010;
        ticks(9);
        keys[1] = 4'b0110;
        ticks(3);
        keys[1] = 4'b0010;
        tick();
        keys[1] = 4'b0000; tick();
        keys[1] = 4'b0010; tick();
        keys[1] = 4'b0000;
        ticks(6);

        // Two keys in row 0 never accepted
        keys[0] = 4'b0011;
        ticks(12);
        keys[0] = 4'b0000;
        ticks(2);

        // Reset during debounce of key D
        keys[3] = 4'b1000;
        reached = 0;
        for (int i = 0; i < 8 && reached == 0; i++) begin
            tick();
            if (m_mode == M_DEB) reached = 1;
        end
        check("reach_debounce", 8'(reached), 8'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        keys[3] = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        ticks(6);

        // Randomized presses with optional bounce and multi-key patterns
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) pat = 4'b0011 << $urandom_range(0, 2);
            else pat = 4'b0001 << $urandom_range(0, 3);
            for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
                keys[r] = pat;   tick();
                keys[r] = 4'h0;  tick();
            end
            keys[r] = pat;
            ticks($urandom_range(0, 12));
            for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
                keys[r] = 4'h0;  tick();
                keys[r] = pat;   tick();
            end
            keys[r] = 4'h0;
            ticks($urandom_range(1, 8));
        end
        ticks(8);

        check("total_presses", 8'(obs_presses), 8'(m_presses));
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
